// File: rtl/pkt_ingest_fifo.sv
// Store-and-forward ingest buffer in front of wr_ctrl: frames from an Avalon-ST sink are held in a
// show-ahead word FIFO, and one ring-addressed command is issued for each completed frame.
module pkt_ingest_fifo #(
    parameter int          DEPTH         = 512,
    parameter int          LEN_DEPTH     = 8,
    parameter int          MAX_PKT_WORDS = 384,
    parameter logic [31:0] BUF_BASE      = 32'h8000,
    parameter logic [31:0] BUF_SIZE      = 32'h10000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] st_data,
    input  logic        st_valid,
    output logic        st_ready,
    input  logic        st_sop,
    input  logic        st_eop,
    input  logic [1:0]  st_empty,
    output logic        wr_ctrl,
    input  logic        wr_ctrl_rdy,
    output logic [31:0] control,
    output logic [31:0] pkt_begin,
    output logic [31:0] pkt_end,
    output logic [31:0] write_address,
    output logic [31:0] fifo_out,
    output logic        empty,
    input  logic        rd_from_fifo,
    output logic [31:0] pkt_cnt,
    output logic [15:0] trunc_cnt
);

    localparam int AW  = $clog2(DEPTH);
    localparam int LAW = $clog2(LEN_DEPTH);
    localparam logic [AW:0]    FIFO_FULL = (AW+1)'(DEPTH);
    localparam logic [LAW:0]   LQ_FULL   = (LAW+1)'(LEN_DEPTH);
    localparam logic [LAW+1:0] LQ_LIMIT  = (LAW+2)'(LEN_DEPTH);
    localparam logic [15:0]    MAX_W     = 16'(MAX_PKT_WORDS);

    typedef struct packed {
        logic [15:0] len;
        logic        trunc;
        logic [15:0] words;
    } ent_t;

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_BUSY} state_t;

    // ------------------------------------------------------------------
    // Data FIFO (show-ahead)
    // ------------------------------------------------------------------
    logic [31:0]   mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [AW:0]   fcount;
    logic          fifo_full, push_word, pop_word;

    assign fifo_full = (fcount == FIFO_FULL);
    assign empty     = (fcount == '0);
    assign pop_word  = rd_from_fifo && !empty;
    assign fifo_out  = empty ? 32'd0 : mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (push_word) mem[wr_ptr] <= st_data;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            fcount <= '0;
        end else begin
            if (push_word) wr_ptr <= wr_ptr + AW'(1);
            if (pop_word)  rd_ptr <= rd_ptr + AW'(1);
            fcount <= fcount + (AW+1)'(push_word) - (AW+1)'(pop_word);
        end
    end

    // ------------------------------------------------------------------
    // Frame ingest
    // ------------------------------------------------------------------
    logic        in_frame, trunc;
    logic [15:0] wc, len_acc;
    logic        close_pend, eop_pend;
    ent_t        close_ent, eop_ent;
    logic        lenq_full, discarding, beat_acc, frame_beat, under_cap;
    logic [15:0] wc_next, len_next;
    logic        trunc_next;

    assign discarding = in_frame && (wc >= MAX_W);
    assign st_ready   = discarding ? !lenq_full : (!fifo_full && !lenq_full);
    assign beat_acc   = st_valid && st_ready;
    assign frame_beat = beat_acc && (st_sop || in_frame);
    assign under_cap  = st_sop || (wc < MAX_W);
    // A sop accepted while discarding may find the FIFO full; that word is dropped and flagged.
    assign push_word  = frame_beat && under_cap && (!fifo_full || pop_word);

    always_comb begin
        wc_next    = (st_sop ? 16'd0 : wc) + {15'd0, push_word};
        len_next   = (st_sop ? 16'd0 : len_acc) + 16'd4;
        trunc_next = (st_sop ? 1'b0 : trunc) | !push_word;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            in_frame   <= 1'b0;
            trunc      <= 1'b0;
            wc         <= '0;
            len_acc    <= '0;
            close_pend <= 1'b0;
            eop_pend   <= 1'b0;
            close_ent  <= '0;
            eop_ent    <= '0;
        end else begin
            close_pend <= 1'b0;
            eop_pend   <= 1'b0;
            if (frame_beat) begin
                wc       <= wc_next;
                len_acc  <= len_next;
                trunc    <= trunc_next;
                in_frame <= !st_eop;
                if (st_eop) begin
                    eop_pend <= 1'b1;
                    eop_ent  <= '{len: len_next - {14'd0, st_empty}, trunc: trunc_next, words: wc_next};
                end
            end
            // A sop inside a frame closes the old frame as a full-word eop.
            if (beat_acc && st_sop && in_frame) begin
                close_pend <= 1'b1;
                close_ent  <= '{len: len_acc, trunc: trunc, words: wc};
            end
        end
    end

    // ------------------------------------------------------------------
    // Length / command queue
    // ------------------------------------------------------------------
    ent_t           lq_mem [LEN_DEPTH];
    logic [LAW-1:0] lq_wr, lq_rd;
    logic [LAW:0]   lq_count;
    logic [LAW+1:0] lq_load, lq_load_a;
    logic           push_a, push_b, take;
    ent_t           head;

    // Pending entries count against capacity so st_ready never over-commits the queue.
    assign lq_load   = {1'b0, lq_count} + (LAW+2)'(close_pend) + (LAW+2)'(eop_pend);
    assign lenq_full = (lq_load >= LQ_LIMIT);
    assign push_a    = close_pend && (lq_count != LQ_FULL);
    assign lq_load_a = {1'b0, lq_count} + (LAW+2)'(push_a);
    assign push_b    = eop_pend && (lq_load_a < LQ_LIMIT);
    assign head      = lq_mem[lq_rd];

    always_ff @(posedge clk) begin
        if (push_a) lq_mem[lq_wr] <= close_ent;
        if (push_b) lq_mem[lq_wr + LAW'(push_a)] <= eop_ent;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            lq_wr    <= '0;
            lq_rd    <= '0;
            lq_count <= '0;
        end else begin
            lq_wr <= lq_wr + LAW'(push_a) + LAW'(push_b);
            if (take) lq_rd <= lq_rd + LAW'(1);
            lq_count <= lq_count + (LAW+1)'(push_a) + (LAW+1)'(push_b) - (LAW+1)'(take);
        end
    end

    // ------------------------------------------------------------------
    // Issue FSM and ring placement
    // ------------------------------------------------------------------
    state_t      state;
    logic [31:0] off, head_bytes, base_off, next_off;
    logic [32:0] fit_sum;

    assign take       = (state == S_IDLE) && (lq_count != '0) && wr_ctrl_rdy;
    assign head_bytes = {14'd0, head.words, 2'b00};
    assign fit_sum    = {1'b0, off} + {1'b0, head_bytes};
    // Restart at the ring base rather than split a frame across the end.
    assign base_off   = (fit_sum > {1'b0, BUF_SIZE}) ? 32'd0 : off;
    assign next_off   = base_off + head_bytes;
    assign pkt_begin  = 32'd0;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state         <= S_IDLE;
            wr_ctrl       <= 1'b0;
            control       <= '0;
            pkt_end       <= '0;
            write_address <= BUF_BASE;
            off           <= '0;
            pkt_cnt       <= '0;
            trunc_cnt     <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (take) begin
                        state         <= S_ISSUE;
                        wr_ctrl       <= 1'b1;
                        control       <= {15'd0, head.trunc, head.len};
                        pkt_end       <= head_bytes;
                        write_address <= BUF_BASE + base_off;
                        off           <= (next_off == BUF_SIZE) ? 32'd0 : next_off;
                        pkt_cnt       <= pkt_cnt + 32'd1;
                        if (head.trunc && (trunc_cnt != 16'hFFFF)) trunc_cnt <= trunc_cnt + 16'd1;
                    end
                end
                S_ISSUE: begin
                    if (!wr_ctrl_rdy) begin
                        state   <= S_BUSY;
                        wr_ctrl <= 1'b0;
                    end
                end
                S_BUSY: begin
                    if (wr_ctrl_rdy) state <= S_IDLE;
                end
                default: begin
                    state   <= S_IDLE;
                    wr_ctrl <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/pkt_ingest_fifo.md
# pkt_ingest_fifo

Upstream feeder for `wr_ctrl`: accepts captured Ethernet frames on an Avalon-ST sink, buffers them store-and-forward in an internal word FIFO, and issues one `wr_ctrl` command per complete frame. Frames are placed in a circular DDR region. Each frame's original length and truncation status travel in `control`. `wr_ctrl` drains the payload through `fifo_out`/`rd_from_fifo`.

## Interface
Parameters:
- DEPTH, 512: data FIFO depth in 32-bit words; power of two.
- LEN_DEPTH, 8: length/command queue depth in frames; power of two.
- MAX_PKT_WORDS, 384: capture limit per frame in words; must be ≤ DEPTH.
- BUF_BASE, 'h8000: byte base address of the ring.
- BUF_SIZE, 'h10000: ring size in bytes; multiple of 4, ≥ 4*MAX_PKT_WORDS.

Ports:
- clk  in  1  single clock domain.
- reset  in  1  synchronous, active-low.
- st_data  in  32  frame word, first byte in [31:24].
- st_valid  in  1  sink beat valid.
- st_ready  out  1  sink ready.
- st_sop  in  1  first beat of frame.
- st_eop  in  1  last beat of frame.
- st_empty  in  2  unused bytes in eop beat (0–3).
- wr_ctrl  out  1  command request to `wr_ctrl`.
- wr_ctrl_rdy  in  1  `wr_ctrl` idle/ready.
- control  out  32  [15:0] original frame byte length, [16] truncated, [31:17] 0.
- pkt_begin  out  32  always 0.
- pkt_end  out  32  bytes to write = 4 × stored words.
- write_address  out  32  DDR byte address of frame.
- fifo_out  out  32  FIFO head word (show-ahead).
- empty  out  1  FIFO holds no word.
- rd_from_fifo  in  1  pop head word.
- pkt_cnt  out  32  frames issued.
- trunc_cnt  out  16  frames truncated; saturates at 'hFFFF.

## Operation
- Ingest:
  - A beat is accepted when `st_valid && st_ready`.
  - Beats before the first `st_sop` after reset are discarded with `st_ready=1`.
  - A `st_sop` mid-frame closes the current frame as if eop with `st_empty=0`, then starts a new frame.
- Word count `wc` per frame:
  - Accepted words are written to the FIFO while `wc < MAX_PKT_WORDS`.
  - Later beats are accepted and discarded, with `trunc` set.
  - Original byte length `len = 4*beats − st_empty`, 16-bit wrapping.
- On the eop beat, `{len, trunc, stored_words}` is pushed to the length queue next cycle.
- `st_ready = !fifo_full && !lenq_full`. Exception: while discarding truncated beats, `st_ready = !lenq_full`.
- FIFO is show-ahead:
  - `fifo_out` is valid whenever `empty=0`.
  - `rd_from_fifo` while `empty=1` is ignored.
  - Simultaneous push and pop are allowed.
- Issue FSM:
  - IDLE: go to ISSUE when the length queue is non-empty and `wr_ctrl_rdy=1`. On that transition, pop the queue, latch `control`, `pkt_end`, `write_address`, increment `pkt_cnt`, and increment `trunc_cnt` if truncated.
  - ISSUE: `wr_ctrl=1`. Go to BUSY when `wr_ctrl_rdy=0`.
  - BUSY: `wr_ctrl=0`. Go to IDLE when `wr_ctrl_rdy=1`.
- Ring offset `off` (bytes, from BUF_BASE):
  - At IDLE→ISSUE, if `off + pkt_end > BUF_SIZE` then `off := 0` first, so a frame never splits.
  - `write_address = BUF_BASE + off`.
  - Then `off += pkt_end`. If the result equals BUF_SIZE, it becomes 0.
- Command outputs stay stable from entry to ISSUE until the next IDLE→ISSUE.

## Timing
- Reset values:
  - `st_ready`, `empty` = 1.
  - `wr_ctrl`, `control`, `pkt_begin`, `pkt_end`, `fifo_out`, `pkt_cnt`, `trunc_cnt` = 0.
  - `write_address` = BUF_BASE.
  - `off`, FIFO, length queue and FSM are cleared.
- Reset mid-frame or mid-command discards everything. `wr_ctrl` is low the cycle after reset is sampled low.
- A word accepted at edge N appears on `fifo_out` with `empty=0` after edge N.
- A pop at edge N presents the next word after edge N, or raises `empty`.
- Eop accepted at edge N: length queue non-empty after N+1. If IDLE with `wr_ctrl_rdy=1`, `wr_ctrl` rises after N+2.
- `st_ready` is combinational from registered counts only. There is no combinational path from `st_valid`.
- Full boundary: with FIFO at DEPTH and a simultaneous pop, `st_ready` stays 0 that cycle and becomes 1 the following cycle.

## Test plan
- Single frame of 8 beats, data 10..17, `st_empty=0`, `wr_ctrl_rdy=1` → `wr_ctrl` high; `pkt_end=32`, `control=32`, `write_address='h8000`. Popping 8 times yields 10..17, then `empty=1`.
- 3-beat frame with `st_empty=3` → `control=9`, `pkt_end=12`. A second frame lands at `write_address='h800C`.
- 400-beat frame with MAX_PKT_WORDS=384 → 384 words stored; `control[16]=1`, `control[15:0]=1600`, `pkt_end=1536`, `trunc_cnt=1`.
- Hold `rd_from_fifo=0` and stream frames until DEPTH words are stored → `st_ready=0`. One pop → `st_ready=1` one cycle later; no word is lost or duplicated.
- BUF_SIZE='h100, with `off='hF0` and a 32-byte frame → `write_address='h8000` (wrap), then `off='h20`.
- Assert `reset=0` mid-frame and during ISSUE → next cycle `wr_ctrl=0`, `empty=1`, `pkt_cnt=0`. A subsequent frame is issued at `'h8000`.
